alu_flag_unit: RTL

Multi-cycle 8-bit ALU with flag generation for the 65C02 core. It sits directly upstream of `processor_stat_reg`. It reads the current status byte from `instruction_decode_out`, computes the result and the N/V/Z/C flags, and delivers them over the `psr_update_request` / `ack_update_request` handshake. Decimal-mode ADC/SBC adjustment is a compile-time option.

---
 rtl/alu_flag_unit_if.sv | 31 +++
 rtl/alu_flag_unit.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/alu_flag_unit_if.sv
// Operand/command and result/flag bundle between the decoder, alu_flag_unit and the PSR.
// Request/acknowledge: psr_update_request stays high with result and flags stable until a rising edge samples ack_update_request high; that edge drops the request and pulses result_valid.
interface alu_flag_unit_if;
  logic       op_start;
  logic [3:0] op_sel;
  logic [7:0] a_in;
  logic [7:0] b_in;
  logic [7:0] psr_in;
  logic       ack_update_request;
  logic       alu_busy;
  logic [7:0] result;
  logic       result_valid;
  logic       n_result;
  logic       v_result;
  logic       z_result;
  logic       c_result;
  logic       psr_update_request;
  logic [1:0] dbg_state;

  modport master (
    output op_start, op_sel, a_in, b_in, psr_in, ack_update_request,
    input  alu_busy, result, result_valid, n_result, v_result, z_result, c_result,
           psr_update_request, dbg_state
  );

  modport slave (
    input  op_start, op_sel, a_in, b_in, psr_in, ack_update_request,
    output alu_busy, result, result_valid, n_result, v_result, z_result, c_result,
           psr_update_request, dbg_state
  );
endinterface

// File: rtl/alu_flag_unit.sv
// Multi-cycle 8-bit 65C02 ALU producing N/V/Z/C for the PSR over a request/ack handshake.
// Define ALU_DECIMAL_EN to add the DADJ state and BCD correction for ADC/SBC when D=1.
module alu_flag_unit (
  input  logic            phi2,
  input  logic            rst,
  alu_flag_unit_if.slave  alu
);
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DADJ = 2'd2,
    S_REQ  = 2'd3
  } state_t;

  localparam logic [3:0] OP_ADC = 4'h0, OP_SBC = 4'h1, OP_AND = 4'h2, OP_ORA = 4'h3,
                         OP_EOR = 4'h4, OP_ASL = 4'h5, OP_LSR = 4'h6, OP_ROL = 4'h7,
                         OP_ROR = 4'h8, OP_INC = 4'h9, OP_DEC = 4'hA, OP_CMP = 4'hB,
                         OP_BIT = 4'hC;

  state_t     r_state, w_next;
  logic [7:0] r_a, r_b;
  logic [3:0] r_op;
  logic       r_n_in, r_v_in, r_z_in, r_c_in;
  logic [7:0] r_result;
  logic       r_n, r_v, r_z, r_c;
  logic       r_req, r_valid;

  logic       w_busy, w_req_d, w_valid_d;
  logic [1:0] w_dbg;
  logic [7:0] w_b_eff, w_res;
  logic [8:0] w_sum, w_cmp;
  logic       w_n, w_v, w_z, w_c;

`ifdef ALU_DECIMAL_EN
  logic       r_d_in;
  logic [4:0] w_lo;
  logic [7:0] w_adj, w_dres;
  logic       w_dc;
`endif

  always_ff @(posedge phi2) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (alu.op_start) w_next = S_EXEC;
      S_EXEC: begin
        w_next = S_REQ;
`ifdef ALU_DECIMAL_EN
        if (r_d_in && (r_op == OP_ADC || r_op == OP_SBC)) w_next = S_DADJ;
`endif
      end
`ifdef ALU_DECIMAL_EN
      S_DADJ: w_next = S_REQ;
`endif
      S_REQ:  if (alu.ack_update_request) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_busy    = (r_state != S_IDLE);
    w_dbg     = r_state;
    w_req_d   = (w_next == S_REQ);
    w_valid_d = (r_state == S_REQ) && alu.ack_update_request;
  end

  // Binary result and flags from the captured operands; unaffected flags default to the captured PSR.
  always_comb begin
    w_b_eff = (r_op == OP_SBC) ? ~r_b : r_b;
    w_sum   = {1'b0, r_a} + {1'b0, w_b_eff} + {8'd0, r_c_in};
    w_cmp   = {1'b0, r_a} - {1'b0, r_b};
    w_res   = r_a;
    w_n     = r_n_in;
    w_v     = r_v_in;
    w_z     = r_z_in;
    w_c     = r_c_in;
    case (r_op)
      OP_ADC, OP_SBC: begin
        w_res = w_sum[7:0];
        w_c   = w_sum[8];
        w_v   = (r_a[7] == w_b_eff[7]) && (w_sum[7] != r_a[7]);
      end
      OP_AND: w_res = r_a & r_b;
      OP_ORA: w_res = r_a | r_b;
      OP_EOR: w_res = r_a ^ r_b;
      OP_ASL: begin w_res = {r_a[6:0], 1'b0};   w_c = r_a[7]; end
      OP_LSR: begin w_res = {1'b0, r_a[7:1]};   w_c = r_a[0]; end
      OP_ROL: begin w_res = {r_a[6:0], r_c_in}; w_c = r_a[7]; end
      OP_ROR: begin w_res = {r_c_in, r_a[7:1]}; w_c = r_a[0]; end
      OP_INC: w_res = r_a + 8'd1;
      OP_DEC: w_res = r_a - 8'd1;
      OP_CMP: w_c = ~w_cmp[8];
      default: ;
    endcase
    if (r_op <= OP_DEC) begin
      w_n = w_res[7];
      w_z = (w_res == 8'h00);
    end else if (r_op == OP_CMP) begin
      w_n = w_cmp[7];
      w_z = (w_cmp[7:0] == 8'h00);
    end else if (r_op == OP_BIT) begin
      w_n = r_b[7];
      w_v = r_b[6];
      w_z = ((r_a & r_b) == 8'h00);
    end
  end

`ifdef ALU_DECIMAL_EN
  // Operands stay captured through DADJ, so the nibble carry is recomputed rather than stored.
  always_comb begin
    w_lo  = {1'b0, r_a[3:0]} + {1'b0, w_b_eff[3:0]} + {4'd0, r_c_in};
    w_adj = 8'h00;
    w_dc  = r_c;
    if (r_op == OP_ADC) begin
      if ((r_result[3:0] > 4'd9) || (w_lo > 5'd15)) w_adj = w_adj + 8'h06;
      if ({r_c, r_result} > 9'h099) begin
        w_adj = w_adj + 8'h60;
        w_dc  = 1'b1;
      end
    end else begin
      if (w_lo < 5'd16) w_adj = w_adj - 8'h06;
      if (!r_c)         w_adj = w_adj - 8'h60;
    end
    w_dres = r_result + w_adj;
  end
`endif

  always_ff @(posedge phi2) begin
    if (rst) begin
      r_a      <= 8'h00;
      r_b      <= 8'h00;
      r_op     <= 4'h0;
      r_n_in   <= 1'b0;
      r_v_in   <= 1'b0;
      r_z_in   <= 1'b0;
      r_c_in   <= 1'b0;
      r_result <= 8'h00;
      r_n      <= 1'b0;
      r_v      <= 1'b0;
      r_z      <= 1'b0;
      r_c      <= 1'b0;
      r_req    <= 1'b0;
      r_valid  <= 1'b0;
`ifdef ALU_DECIMAL_EN
      r_d_in   <= 1'b0;
`endif
    end else begin
      r_req   <= w_req_d;
      r_valid <= w_valid_d;
      if (r_state == S_IDLE && alu.op_start) begin
        r_a    <= alu.a_in;
        r_b    <= alu.b_in;
        r_op   <= alu.op_sel;
        r_n_in <= alu.psr_in[7];
        r_v_in <= alu.psr_in[6];
        r_z_in <= alu.psr_in[1];
        r_c_in <= alu.psr_in[0];
`ifdef ALU_DECIMAL_EN
        r_d_in <= alu.psr_in[3];
`endif
      end
      if (r_state == S_EXEC) begin
        r_result <= w_res;
        r_n      <= w_n;
        r_v      <= w_v;
        r_z      <= w_z;
        r_c      <= w_c;
      end
`ifdef ALU_DECIMAL_EN
      if (r_state == S_DADJ) begin
        r_result <= w_dres;
        r_c      <= w_dc;
        r_n      <= w_dres[7];
        r_z      <= (w_dres == 8'h00);
      end
`endif
    end
  end

  assign alu.alu_busy           = w_busy;
  assign alu.dbg_state          = w_dbg;
  assign alu.result             = r_result;
  assign alu.result_valid       = r_valid;
  assign alu.n_result           = r_n;
  assign alu.v_result           = r_v;
  assign alu.z_result           = r_z;
  assign alu.c_result           = r_c;
  assign alu.psr_update_request = r_req;
endmodule
